// File: rtl/alu_sout_deserializer_pkg.sv
// Shared types, constants and check functions for the serial ALU response path.
`default_nettype none

package alu_sout_deserializer_pkg;

   typedef enum logic {
      CMD_DATA = 1'b0,
      CMD_CTL  = 1'b1
   } cmd_t;

   typedef enum logic [1:0] {
      RX_OK        = 2'd0,
      RX_CRC_BAD   = 2'd1,
      RX_PAR_BAD   = 2'd2,
      RX_FRAME_BAD = 2'd3
   } rx_status_t;

   localparam int         PKT_BITS  = 11;
   localparam logic [2:0] CRC3_POLY = 3'b011;  // x^3 + x + 1, x^3 term implicit

   localparam logic [3:0] F_CARRY = 4'b1000;
   localparam logic [3:0] F_OVFL  = 4'b0100;
   localparam logic [3:0] F_ZERO  = 4'b0010;
   localparam logic [3:0] F_NEG   = 4'b0001;

   function automatic logic [2:0] crc3(input logic [36:0] msg);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ msg[i];
         crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
      end
      return crc;
   endfunction

   function automatic logic err_parity(input logic [5:0] err_flags);
      return ^{1'b1, err_flags};
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rx_byte.sv
// Packet-level receiver: frames one 11-bit start/cmd/payload/stop packet from sout.
`default_nettype none

module alu_rx_byte
   import alu_sout_deserializer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sout_i,
   output logic       pkt_valid_o,
   output cmd_t       pkt_cmd_o,
   output logic [7:0] pkt_data_o,
   output logic       pkt_stop_err_o
);

   // The start bit is consumed by the IDLE detection itself, keeping packets at 11 cycles.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CMD     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_STOP    = 2'd3
   } pkt_state_t;

   pkt_state_t state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   cmd_t       cmd_q, cmd_d;
   logic       armed_q, armed_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic       stop_err_q, stop_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         cmd_q       <= CMD_DATA;
         armed_q     <= 1'b1;
         pkt_valid_q <= 1'b0;
         stop_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         cmd_q       <= cmd_d;
         armed_q     <= armed_d;
         pkt_valid_q <= pkt_valid_d;
         stop_err_q  <= stop_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      cmd_d       = cmd_q;
      armed_d     = armed_q;
      pkt_valid_d = 1'b0;
      stop_err_d  = stop_err_q;
      case (state_q)
         S_IDLE: begin
            // After a stop error the line must be seen high before a new start is accepted.
            if (!armed_q) begin
               armed_d = sout_i;
            end else if (!sout_i) begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            cmd_d     = cmd_t'(sout_i);
            bit_cnt_d = 3'd0;
            state_d   = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            shift_d   = {shift_q[6:0], sout_i};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            pkt_valid_d = 1'b1;
            stop_err_d  = ~sout_i;
            armed_d     = sout_i;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pkt_valid_o    = pkt_valid_q;
   assign pkt_cmd_o      = cmd_q;
   assign pkt_data_o     = shift_q;
   assign pkt_stop_err_o = stop_err_q;

endmodule

`default_nettype wire

// File: rtl/alu_sout_deserializer.sv
// Reassembles serial ALU responses into one checked result per response strobe.
`default_nettype none

module alu_sout_deserializer
   import alu_sout_deserializer_pkg::*;
#(
   parameter int DATA_BYTES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sout,
   output logic signed [31:0] res_data,
   output logic [5:0]         res_flags,
   output logic               res_is_err,
   output rx_status_t         res_status,
   output logic               res_valid
);

   localparam int             CNT_W    = $clog2(DATA_BYTES + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BYTES);

   typedef enum logic {
      R_WAIT_DATA = 1'b0,
      R_CHECK     = 1'b1
   } resp_state_t;

   logic       pkt_valid;
   cmd_t       pkt_cmd;
   logic [7:0] pkt_data;
   logic       pkt_stop_err;

   alu_rx_byte u_rx_byte (
      .clk           (clk),
      .rst_n         (rst_n),
      .sout_i        (sout),
      .pkt_valid_o   (pkt_valid),
      .pkt_cmd_o     (pkt_cmd),
      .pkt_data_o    (pkt_data),
      .pkt_stop_err_o(pkt_stop_err)
   );

   resp_state_t      state_q, state_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [31:0]      shift_q, shift_d;
   logic             res_valid_q, res_valid_d;
   logic [31:0]      res_data_q, res_data_d;
   logic [5:0]       res_flags_q, res_flags_d;
   logic             res_is_err_q, res_is_err_d;
   rx_status_t       res_status_q, res_status_d;

   logic w_crc_ok;
   logic w_par_ok;

   assign w_crc_ok = (pkt_data[2:0] == crc3({shift_q, 1'b0, pkt_data[6:3]}));
   assign w_par_ok = (pkt_data[0] == err_parity(pkt_data[6:1]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= R_WAIT_DATA;
         byte_cnt_q   <= '0;
         shift_q      <= 32'd0;
         res_valid_q  <= 1'b0;
         res_data_q   <= 32'd0;
         res_flags_q  <= 6'd0;
         res_is_err_q <= 1'b0;
         res_status_q <= RX_OK;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_flags_q  <= res_flags_d;
         res_is_err_q <= res_is_err_d;
         res_status_q <= res_status_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      shift_d      = shift_q;
      res_valid_d  = 1'b0;
      res_data_d   = res_data_q;
      res_flags_d  = res_flags_q;
      res_is_err_d = res_is_err_q;
      res_status_d = res_status_q;
      case (state_q)
         R_WAIT_DATA: begin
            if (pkt_valid) begin
               if (pkt_cmd == CMD_DATA && !pkt_stop_err && byte_cnt_q != CNT_FULL) begin
                  shift_d    = {shift_q[23:0], pkt_data};
                  byte_cnt_d = byte_cnt_q + CNT_W'(1);
               end else begin
                  state_d     = R_CHECK;
                  res_valid_d = 1'b1;
                  res_data_d  = shift_q;
                  if (pkt_cmd == CMD_CTL && pkt_data[7]) begin
                     res_is_err_d = 1'b1;
                     res_flags_d  = pkt_data[6:1];
                     res_status_d = (byte_cnt_q != '0) ? RX_FRAME_BAD :
                                    (!w_par_ok)        ? RX_PAR_BAD   : RX_OK;
                  end else if (pkt_cmd == CMD_CTL) begin
                     res_is_err_d = 1'b0;
                     res_flags_d  = {2'b00, pkt_data[6:3]};
                     res_status_d = (byte_cnt_q != CNT_FULL) ? RX_FRAME_BAD :
                                    (!w_crc_ok)              ? RX_CRC_BAD   : RX_OK;
                  end else begin
                     res_is_err_d = 1'b0;
                     res_flags_d  = 6'd0;
                     res_status_d = RX_FRAME_BAD;
                  end
                  // A broken stop bit outranks anything decoded from the payload.
                  if (pkt_stop_err) begin
                     res_status_d = RX_FRAME_BAD;
                  end
               end
            end
         end
         R_CHECK: begin
            byte_cnt_d = '0;
            shift_d    = 32'd0;
            state_d    = R_WAIT_DATA;
         end
         default: state_d = R_WAIT_DATA;
      endcase
   end

   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_flags  = res_flags_q;
   assign res_is_err = res_is_err_q;
   assign res_status = res_status_q;

endmodule

`default_nettype wire
